axis_sync_fifo_pkt: RTL

Single-clock AXI-Stream FIFO. It is the parametrised successor of the dual-clock AXIS data FIFO wrapper. Adds TKEEP/TLAST sideband, occupancy reporting, programmable almost-full/almost-empty flags, synchronous flush, and an optional store-and-forward packet mode. It sits between AXIS producers and consumers inside one clock domain and buffers whole beats (data+keep+last).

---
 rtl/axis_sync_fifo_pkt.sv | 137 +++++++++++++
 1 files changed

// File: rtl/axis_sync_fifo_pkt.sv
// Single-clock AXI-Stream FIFO with TKEEP/TLAST sideband, occupancy and packet counters,
// almost-full/almost-empty flags, synchronous flush and optional store-and-forward output gating.
module axis_sync_fifo_pkt #(
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int PACKET_MODE   = 0,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                          axis_clk,
    input  logic                          axis_rst_n,
    input  logic                          flush,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   pkt_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [PW-1:0] L_AFULL  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] L_AEMPTY = PW'(AEMPTY_THRESH);

    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_occupancy;
    logic [PW-1:0] r_pkt_count;
    logic          r_almost_full;
    logic          r_almost_empty;
    logic          r_ready_en;

    logic          w_full;
    logic          w_empty;
    logic          w_pkt_ok;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_wr_last;
    logic          w_rd_last;
    logic [EW-1:0] w_head;
    logic [PW-1:0] w_occ_next;
    logic [PW-1:0] w_pkt_next;

    // The MSB of each pointer is the wrap bit, so equal addresses mean full or empty depending on it.
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // In packet mode the full term lets packets longer than the FIFO drain instead of deadlocking.
    assign w_pkt_ok = (PACKET_MODE == 0) || (r_pkt_count != '0) || w_full;

    assign s_axis_tready = r_ready_en && !w_full && !flush;
    assign m_axis_tvalid = !w_empty && w_pkt_ok;

    assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
    assign m_axis_tdata = m_axis_tvalid ? w_head[DATA_WIDTH-1:0] : '0;
    assign m_axis_tkeep = m_axis_tvalid ? w_head[DATA_WIDTH +: KEEP_WIDTH] : '0;
    assign m_axis_tlast = m_axis_tvalid ? w_head[EW-1] : 1'b0;

    assign w_wr_en   = s_axis_tvalid && s_axis_tready;
    assign w_rd_en   = m_axis_tvalid && m_axis_tready;
    assign w_wr_last = w_wr_en && s_axis_tlast;
    assign w_rd_last = w_rd_en && m_axis_tlast;

    assign occupancy    = r_occupancy;
    assign pkt_count    = r_pkt_count;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;

    always_ff @(posedge axis_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_comb begin
        w_occ_next = r_occupancy;
        w_pkt_next = r_pkt_count;
        if (flush) begin
            w_occ_next = '0;
            w_pkt_next = '0;
        end else begin
            if (w_wr_en && !w_rd_en) begin
                w_occ_next = r_occupancy + PW'(1);
            end else if (!w_wr_en && w_rd_en) begin
                w_occ_next = r_occupancy - PW'(1);
            end
            if (w_wr_last && !w_rd_last) begin
                w_pkt_next = r_pkt_count + PW'(1);
            end else if (!w_wr_last && w_rd_last) begin
                w_pkt_next = r_pkt_count - PW'(1);
            end
        end
    end

    // Flags are registered from the next occupancy so they move on the same edge as the pointers.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_occupancy    <= '0;
            r_pkt_count    <= '0;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_ready_en     <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_rd_en) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
            r_occupancy    <= w_occ_next;
            r_pkt_count    <= w_pkt_next;
            r_almost_full  <= (w_occ_next >= L_AFULL);
            r_almost_empty <= (w_occ_next <= L_AEMPTY);
        end
    end

endmodule
